dvi_timing: RTL

- Raster timing generator that sits directly upstream of the TMDS encoder.
- Produces the per-pixel den, hsync and vsync that drive the encoder's den and c inputs; c[0]=hsync and c[1]=vsync on the blue channel.
- Gives upstream pixel sources a one-cycle-early pixel request, plus start-of-frame and end-of-line markers.
- Two cascaded phase counters (horizontal, vertical), each a 4-state machine. Clock-enable input supports pixel-clock dividers.

---
 rtl/dvi_timing_pkg.sv | 31 +++
 rtl/dvi_timing_axis.sv | 68 ++++++
 rtl/dvi_timing.sv | 109 ++++++++++
 3 files changed

// File: rtl/dvi_timing_pkg.sv
// -----------------------------------------------------------------------------
// dvi_timing_pkg
// Shared definitions for the DVI raster timing generator:
//   - phase_e      : per-axis phase encoding (SYNC=0, BACK=1, ACTIVE=2, FRONT=3)
//   - C_*_BIT      : bit positions of hsync/vsync in the TMDS blue-channel
//                    control symbol c[1:0]
//   - next_phase() : phase successor, SYNC -> BACK -> ACTIVE -> FRONT -> SYNC
// -----------------------------------------------------------------------------
package dvi_timing_pkg;

    typedef enum logic [1:0] {
        PH_SYNC   = 2'd0,
        PH_BACK   = 2'd1,
        PH_ACTIVE = 2'd2,
        PH_FRONT  = 2'd3
    } phase_e;

    // TMDS control symbol mapping on the blue channel.
    localparam int C_HSYNC_BIT = 0;
    localparam int C_VSYNC_BIT = 1;

    function automatic phase_e next_phase(input phase_e ph);
        case (ph)
            PH_SYNC:   return PH_BACK;
            PH_BACK:   return PH_ACTIVE;
            PH_ACTIVE: return PH_FRONT;
            default:   return PH_SYNC;
        endcase
    endfunction

endpackage

// File: rtl/dvi_timing_axis.sv
// -----------------------------------------------------------------------------
// dvi_timing_axis
// One raster axis: a 4-phase state machine with a down-counter that holds the
// remaining length of the current phase. Used once for the horizontal axis
// (pixels) and once for the vertical axis (lines).
//
// Ports:
//   clk            in   pixel clock
//   rst            in   synchronous reset, active-high (SYNC, count = SYNC_LEN-1)
//   step           in   advance one position on this axis
//   state          out  current phase
//   last_in_phase  out  last position of FRONT (the next step wraps the axis)
//   at_phase_end   out  last position of the current phase (counter == 0)
//   at_phase_start out  first position of the current phase
// -----------------------------------------------------------------------------
module dvi_timing_axis
    import dvi_timing_pkg::*;
#(
    parameter int unsigned SYNC_LEN   = 96,
    parameter int unsigned BACK_LEN   = 48,
    parameter int unsigned ACTIVE_LEN = 640,
    parameter int unsigned FRONT_LEN  = 16,
    parameter int          W_CTR      = 12
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   step,
    output phase_e state,
    output logic   last_in_phase,
    output logic   at_phase_end,
    output logic   at_phase_start
);

    logic [W_CTR-1:0] count;

    // Counter value loaded on entry to a phase: its length minus one.
    function automatic logic [W_CTR-1:0] phase_reload(input phase_e ph);
        case (ph)
            PH_SYNC:   return W_CTR'(SYNC_LEN - 1);
            PH_BACK:   return W_CTR'(BACK_LEN - 1);
            PH_ACTIVE: return W_CTR'(ACTIVE_LEN - 1);
            default:   return W_CTR'(FRONT_LEN - 1);
        endcase
    endfunction

    // NOTE: state and counter are clocked registers, so they take non-blocking
    // assignments; the reset branch sits inside the clocked block because this
    // reset is synchronous, and it outranks step.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PH_SYNC;
            count <= phase_reload(PH_SYNC);
        end else if (step) begin
            if (count == '0) begin
                // Phase exhausted: move on and reload, so the counter never wraps.
                state <= next_phase(state);
                count <= phase_reload(next_phase(state));
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    assign at_phase_end   = (count == '0);
    assign at_phase_start = (count == phase_reload(state));
    assign last_in_phase  = at_phase_end && (state == PH_FRONT);

endmodule

// File: rtl/dvi_timing.sv
// -----------------------------------------------------------------------------
// dvi_timing
// Raster timing generator feeding the TMDS encoder. A horizontal axis steps on
// every enabled clock; the vertical axis steps when the horizontal axis wraps
// out of FRONT, so vsync edges line up with hsync leading edges. All outputs
// are decoded from the axis state registers only, so en/rst never reach an
// output combinationally and a stalled (en=0) generator holds every output.
//
// Ports:
//   clk    in   pixel clock (same as the TMDS encoder)
//   rst    in   synchronous reset, active-high, priority over en
//   en     in   clock enable for pixel-clock dividers
//   hsync  out  horizontal sync, equal to H_SYNC_POLARITY while asserted
//   vsync  out  vertical sync, equal to V_SYNC_POLARITY while asserted
//   den    out  active video, drives encoder den
//   rdy    out  den will be high on the next enabled cycle
//   sof    out  first den cycle of a frame
//   eol    out  last den cycle of a line
// -----------------------------------------------------------------------------
module dvi_timing
    import dvi_timing_pkg::*;
#(
    parameter logic H_SYNC_POLARITY = 1'b0,
    parameter int   H_FRONT_PORCH   = 16,
    parameter int   H_SYNC_WIDTH    = 96,
    parameter int   H_BACK_PORCH    = 48,
    parameter int   H_ACTIVE_PIXELS = 640,
    parameter logic V_SYNC_POLARITY = 1'b0,
    parameter int   V_FRONT_PORCH   = 10,
    parameter int   V_SYNC_WIDTH    = 2,
    parameter int   V_BACK_PORCH    = 33,
    parameter int   V_ACTIVE_LINES  = 480,
    parameter int   W_CTR           = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic hsync,
    output logic vsync,
    output logic den,
    output logic rdy,
    output logic sof,
    output logic eol
);

    phase_e     h_state, v_state;
    logic       h_wrap, h_end, h_start;
    logic       v_wrap, v_end, v_start;
    logic       v_step;
    logic [1:0] ctrl;

    // The vertical axis moves exactly when the horizontal axis leaves FRONT.
    assign v_step = en & h_wrap;

    dvi_timing_axis #(
        .SYNC_LEN   (H_SYNC_WIDTH),
        .BACK_LEN   (H_BACK_PORCH),
        .ACTIVE_LEN (H_ACTIVE_PIXELS),
        .FRONT_LEN  (H_FRONT_PORCH),
        .W_CTR      (W_CTR)
    ) u_h_axis (
        .clk            (clk),
        .rst            (rst),
        .step           (en),
        .state          (h_state),
        .last_in_phase  (h_wrap),
        .at_phase_end   (h_end),
        .at_phase_start (h_start)
    );

    dvi_timing_axis #(
        .SYNC_LEN   (V_SYNC_WIDTH),
        .BACK_LEN   (V_BACK_PORCH),
        .ACTIVE_LEN (V_ACTIVE_LINES),
        .FRONT_LEN  (V_FRONT_PORCH),
        .W_CTR      (W_CTR)
    ) u_v_axis (
        .clk            (clk),
        .rst            (rst),
        .step           (v_step),
        .state          (v_state),
        .last_in_phase  (v_wrap),
        .at_phase_end   (v_end),
        .at_phase_start (v_start)
    );

    // Frame wrap and end-of-line-phase on the vertical axis have no consumer here.
    logic unused_v;
    assign unused_v = v_wrap ^ v_end;

    // Control symbol as presented to the encoder's blue channel.
    assign ctrl[C_HSYNC_BIT] = (h_state == PH_SYNC) ? H_SYNC_POLARITY : ~H_SYNC_POLARITY;
    assign ctrl[C_VSYNC_BIT] = (v_state == PH_SYNC) ? V_SYNC_POLARITY : ~V_SYNC_POLARITY;

    assign hsync = ctrl[C_HSYNC_BIT];
    assign vsync = ctrl[C_VSYNC_BIT];

    assign den = (h_state == PH_ACTIVE) && (v_state == PH_ACTIVE);

    // Next step reaches active video: either BACK is on its last pixel, or
    // ACTIVE still has pixels left after this one.
    assign rdy = (v_state == PH_ACTIVE) &&
                 (((h_state == PH_BACK)   &&  h_end) ||
                  ((h_state == PH_ACTIVE) && !h_end));

    assign sof = den && h_start && v_start;
    assign eol = den && h_end;

endmodule
